// File: rtl/arith_control_unit_if.sv
// Handshake and datapath control bundle for arith_control_unit.
// The slave modport is the sequencer; master is the caller/datapath side.
interface arith_control_unit_if;
    logic        start;
    logic [1:0]  op;
    logic        in_valid;
    logic        cnt_done;
    logic        q0;
    logic        qm1;
    logic        a7;
    logic [10:0] c;
    logic [1:0]  op_out;
    logic        internal_rst;
    logic        in_req;
    logic        in_sel;
    logic        busy;
    logic        out_valid;
    logic        out_hi;
    logic        done;

    modport master (
        output start, op, in_valid,
        output cnt_done, q0, qm1, a7,
        input  c, op_out, internal_rst,
        input  in_req, in_sel, busy,
        input  out_valid, out_hi, done
    );

    modport slave (
        input  start, op, in_valid,
        input  cnt_done, q0, qm1, a7,
        output c, op_out, internal_rst,
        output in_req, in_sel, busy,
        output out_valid, out_hi, done
    );
endinterface

// File: rtl/arith_control_unit.sv
// Sequencer for the 8-bit arithmetic datapath: add, sub,
// Booth signed multiply and restoring unsigned divide.
module arith_control_unit (
    input logic                 clk,
    input logic                 rst,
    arith_control_unit_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE,
        CLR,
        LD_X,
        LD_Y,
        M_ADD,
        M_SHIFT,
        D_SHIFT,
        D_SUB,
        D_FIX,
        OUT_HI,
        OUT_LO
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic       last_q, last_d;

    logic [1:0] op_out_q;
    logic       busy_q;
    logic       irst_q;
    logic       in_req_q;
    logic       in_sel_q;
    logic       out_valid_q;
    logic       out_hi_q;
    logic       done_q;
    logic       shift_q;
    logic       dsub_q;
    logic       c7_q;
    logic       c8_q;
    logic       c3out_q;

    logic       c0_m;
    logic       c1_m;
    logic       c2_m;
    logic       c3_m;
    logic       c6_m;
    logic       c10_m;
    logic       c2_w;
    logic       c3_w;

    // Next-state and opcode/last-iteration bookkeeping.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CLR;
                    op_d    = bus.op;
                end
            end
            CLR: begin
                state_d = LD_X;
                last_d  = 1'b0;
            end
            LD_X: begin
                if (bus.in_valid) begin
                    state_d = LD_Y;
                end
            end
            LD_Y: begin
                if (bus.in_valid) begin
                    unique case (op_q)
                        2'b10:   state_d = M_ADD;
                        2'b11:   state_d = D_SHIFT;
                        default: state_d = OUT_HI;
                    endcase
                end
            end
            M_ADD: begin
                state_d = M_SHIFT;
            end
            M_SHIFT: begin
                state_d = bus.cnt_done ? OUT_HI : M_ADD;
            end
            D_SHIFT: begin
                state_d = D_SUB;
                last_d  = bus.cnt_done;
            end
            D_SUB: begin
                state_d = D_FIX;
            end
            D_FIX: begin
                state_d = last_q ? OUT_HI : D_SHIFT;
            end
            OUT_HI: begin
                state_d = OUT_LO;
            end
            OUT_LO: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register plus outputs that depend only on the state entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            op_q        <= 2'b00;
            last_q      <= 1'b0;
            op_out_q    <= 2'b00;
            busy_q      <= 1'b0;
            irst_q      <= 1'b0;
            in_req_q    <= 1'b0;
            in_sel_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_hi_q    <= 1'b0;
            done_q      <= 1'b0;
            shift_q     <= 1'b0;
            dsub_q      <= 1'b0;
            c7_q        <= 1'b0;
            c8_q        <= 1'b0;
            c3out_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            last_q      <= last_d;
            op_out_q    <= (state_d == IDLE) ? 2'b00 : op_d;
            busy_q      <= (state_d != IDLE);
            irst_q      <= (state_d == CLR);
            in_req_q    <= (state_d == LD_X) || (state_d == LD_Y);
            in_sel_q    <= (state_d == LD_Y);
            out_valid_q <= (state_d == OUT_HI) || (state_d == OUT_LO);
            out_hi_q    <= (state_d == OUT_HI);
            done_q      <= (state_d == OUT_LO);
            shift_q     <= (state_d == M_SHIFT) || (state_d == D_SHIFT);
            dsub_q      <= (state_d == D_SUB);
            c7_q        <= (state_d == OUT_HI);
            c8_q        <= (state_d == OUT_LO);
            c3out_q     <= ((state_d == OUT_HI) || (state_d == OUT_LO))
                           && !op_d[1] && op_d[0];
        end
    end

    // Control bits that must react to handshake or status in the same cycle.
    always_comb begin
        c0_m  = 1'b0;
        c1_m  = 1'b0;
        c2_m  = 1'b0;
        c3_m  = 1'b0;
        c6_m  = 1'b0;
        c10_m = 1'b0;
        unique case (state_q)
            LD_X: begin
                c1_m = bus.in_valid;
            end
            LD_Y: begin
                c0_m = bus.in_valid;
            end
            M_ADD: begin
                unique case ({bus.q0, bus.qm1})
                    2'b01: begin
                        c2_m = 1'b1;
                    end
                    2'b10: begin
                        c2_m = 1'b1;
                        c3_m = 1'b1;
                    end
                    default: begin
                        c2_m = 1'b0;
                    end
                endcase
            end
            M_SHIFT: begin
                c6_m = bus.a7;
            end
            D_FIX: begin
                c10_m = 1'b1;
                if (bus.a7) begin
                    c2_m = 1'b1;
                end else begin
                    c6_m = 1'b1;
                end
            end
            default: begin
                c0_m = 1'b0;
            end
        endcase
    end

    assign c2_w = c2_m | dsub_q;
    assign c3_w = c3_m | dsub_q | c3out_q;

    assign bus.c = {
        c10_m,
        1'b0,
        c8_q,
        c7_q,
        c6_m,
        shift_q,
        shift_q,
        c3_w,
        c2_w,
        c1_m,
        c0_m
    };

    assign bus.op_out       = op_out_q;
    assign bus.internal_rst = irst_q;
    assign bus.in_req       = in_req_q;
    assign bus.in_sel       = in_sel_q;
    assign bus.busy         = busy_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_hi       = out_hi_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_arith_control_unit.sv
// Bench for arith_control_unit: behavioural datapath plus
// arithmetic reference results and latency expectations.
module tb_arith_control_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arith_control_unit_if bus ();

    arith_control_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Datapath environment driven by the control word.
    logic [7:0] in_bus = 8'h00;
    logic [7:0] dp_a = 8'h00;
    logic [7:0] dp_q = 8'h00;
    logic [7:0] dp_m = 8'h00;
    logic       dp_qm1 = 1'b0;
    logic [2:0] dp_cnt = 3'd0;
    logic [8:0] dp_sum;
    logic [7:0] dp_out;

    assign bus.cnt_done = (dp_cnt == 3'd7);
    assign bus.q0       = dp_q[0];
    assign bus.qm1      = dp_qm1;
    assign bus.a7       = dp_a[7];

    assign dp_sum = bus.c[3] ? ({1'b0, dp_q} - {1'b0, dp_m})
                             : ({1'b0, dp_q} + {1'b0, dp_m});

    always_comb begin
        dp_out = 8'h00;
        if (bus.c[7]) begin
            dp_out = bus.op_out[1] ? dp_a : {8{dp_sum[8]}};
        end else if (bus.c[8]) begin
            dp_out = bus.op_out[1] ? dp_q : dp_sum[7:0];
        end
    end

    always @(posedge clk) begin
        if (bus.internal_rst) begin
            dp_a   <= 8'h00;
            dp_q   <= 8'h00;
            dp_m   <= 8'h00;
            dp_qm1 <= 1'b0;
            dp_cnt <= 3'd0;
        end else begin
            if (bus.c[0]) dp_m <= in_bus;
            if (bus.c[1]) dp_q <= in_bus;
            if (bus.c[2]) dp_a <= bus.c[3] ? dp_a - dp_m : dp_a + dp_m;
            if (bus.c[4] && bus.c[5]) begin
                dp_cnt <= dp_cnt + 3'd1;
                if (bus.op_out == 2'b10)
                    {dp_a, dp_q, dp_qm1} <= {bus.c[6], dp_a, dp_q};
                else
                    {dp_a, dp_q} <= {dp_a[6:0], dp_q, bus.c[6]};
            end
            if (bus.c[10]) dp_q[0] <= bus.c[6];
        end
    end

    // Reference results from plain arithmetic.
    function automatic logic [15:0] ref_result(input logic [1:0] op,
                                               input logic [7:0] x,
                                               input logic [7:0] y);
        int s;
        case (op)
            2'b00: begin
                s = int'(x) + int'(y);
                return {(s > 255) ? 8'hFF : 8'h00, 8'(s)};
            end
            2'b01: begin
                s = int'(x) - int'(y);
                return {(s < 0) ? 8'hFF : 8'h00, 8'(s)};
            end
            2'b10: begin
                s = int'($signed(x)) * int'($signed(y));
                return 16'(s);
            end
            default: begin
                if (y == 8'h00) return {x, 8'hFF};
                return {8'(x % y), 8'(x / y)};
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] op);
        case (op)
            2'b10:   return 22;
            2'b11:   return 30;
            default: return 6;
        endcase
    endfunction

    logic [7:0]  r_hi;
    logic [7:0]  r_lo;
    int          r_lat;
    int          r_c1;
    int          r_c0;
    int          r_sh;
    int          r_c6bad;
    bit          r_to;
    logic [19:0] r_snap;

    function automatic logic [19:0] snap();
        return {bus.c, bus.op_out, bus.internal_rst, bus.in_req,
                bus.in_sel, bus.busy, bus.out_valid, bus.out_hi,
                bus.done};
    endfunction

    // Drives one operation from the IDLE cycle through done.
    task automatic run_op(input logic [1:0] op, input logic [7:0] x,
                          input logic [7:0] y, input int stx,
                          input int sty, input bit mid_start,
                          input bit abort, input bit hold_end);
        int cyc;
        bit fin;
        r_hi = 8'h00; r_lo = 8'h00; r_lat = 0; r_c1 = 0; r_c0 = 0;
        r_sh = 0; r_c6bad = 0; r_to = 1'b0; r_snap = '1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = op;
        bus.in_valid = 1'($urandom_range(0, 1));
        in_bus = 8'($urandom);
        cyc = 1;
        fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            bus.start = mid_start && (cyc == 10);
            bus.op = 2'($urandom);
            bus.in_valid = 1'b0;
            in_bus = 8'($urandom);
            if (bus.in_req && !bus.in_sel) begin
                if (stx > 0) stx--;
                else begin bus.in_valid = 1'b1; in_bus = x; end
            end else if (bus.in_req && bus.in_sel) begin
                if (sty > 0) sty--;
                else begin bus.in_valid = 1'b1; in_bus = y; end
            end else begin
                bus.in_valid = 1'($urandom_range(0, 1));
            end
            #1;
            if (bus.c[1]) r_c1++;
            if (bus.c[0]) r_c0++;
            if (bus.c[4] && bus.c[5] && op == 2'b10) begin
                r_sh++;
                if (bus.c[6] !== bus.a7) r_c6bad++;
            end
            if (bus.out_valid && bus.out_hi) r_hi = dp_out;
            if (bus.out_valid && !bus.out_hi) r_lo = dp_out;
            if (abort && op == 2'b11 && bus.c[2] && bus.c[3]
                && !bus.c[10]) begin
                rst = 1'b0;
                #1;
                r_snap = snap();
                fin = 1'b1;
                bus.start = 1'b0;
                bus.in_valid = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end else if (bus.done) begin
                r_lat = cyc;
                fin = 1'b1;
                bus.start = hold_end;
            end else if (cyc > 300) begin
                r_to = 1'b1;
                fin = 1'b1;
                bus.start = 1'b0;
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (snap() !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", snap());
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (snap() !== 20'h0) begin
            n_fail++;
            $display("FAIL idle_outputs: got %h expected 0", snap());
        end
    endtask

    task automatic test_add();
        run_op(2'b00, 8'hC8, 8'h64, 0, 0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({r_to, r_hi, r_lo} !== {1'b0, 16'hFF2C}) begin
            n_fail++;
            $display("FAIL add_result: got %b/%h%h expected 0/FF2C",
                     r_to, r_hi, r_lo);
        end
        n_cmp++;
        if (r_lat !== 6) begin
            n_fail++;
            $display("FAIL add_latency: got %0d expected 6", r_lat);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL add_busy_after: got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_mul();
        run_op(2'b10, 8'h03, 8'hFB, 0, 0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({r_to, r_hi, r_lo} !== {1'b0, 16'hFFF1}) begin
            n_fail++;
            $display("FAIL mul_result: got %b/%h%h expected 0/FFF1",
                     r_to, r_hi, r_lo);
        end
        n_cmp++;
        if (r_lat !== 22) begin
            n_fail++;
            $display("FAIL mul_latency: got %0d expected 22", r_lat);
        end
        n_cmp++;
        if (r_sh !== 8) begin
            n_fail++;
            $display("FAIL mul_shifts: got %0d expected 8", r_sh);
        end
        n_cmp++;
        if (r_c6bad !== 0) begin
            n_fail++;
            $display("FAIL mul_c6_a7: got %0d bad expected 0", r_c6bad);
        end
    endtask

    task automatic test_div();
        run_op(2'b11, 8'h64, 8'h07, 0, 0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({r_to, r_hi, r_lo} !== {1'b0, 16'h020E}) begin
            n_fail++;
            $display("FAIL div_result: got %b/%h%h expected 0/020E",
                     r_to, r_hi, r_lo);
        end
        n_cmp++;
        if (r_lat !== 30) begin
            n_fail++;
            $display("FAIL div_latency: got %0d expected 30", r_lat);
        end
    endtask

    task automatic test_div_zero();
        run_op(2'b11, 8'h2A, 8'h00, 0, 0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({r_to, r_hi, r_lo} !== {1'b0, 16'h2AFF}) begin
            n_fail++;
            $display("FAIL div0_result: got %b/%h%h expected 0/2AFF",
                     r_to, r_hi, r_lo);
        end
    endtask

    task automatic test_stall();
        run_op(2'b10, 8'hE7, 8'h0D, 5, 3, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({r_c1, r_c0} !== {32'd1, 32'd1}) begin
            n_fail++;
            $display("FAIL stall_pulses: got c1=%0d c0=%0d expected 1/1",
                     r_c1, r_c0);
        end
        n_cmp++;
        if (r_lat !== 30) begin
            n_fail++;
            $display("FAIL stall_latency: got %0d expected 30", r_lat);
        end
        n_cmp++;
        if ({r_hi, r_lo} !== ref_result(2'b10, 8'hE7, 8'h0D)) begin
            n_fail++;
            $display("FAIL stall_result: got %h%h expected %h", r_hi, r_lo,
                     ref_result(2'b10, 8'hE7, 8'h0D));
        end
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_no_queue: got busy %b expected 0",
                     bus.busy);
        end
    endtask

    task automatic test_reset_mid_div();
        run_op(2'b11, 8'h64, 8'h07, 0, 0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (r_snap !== 20'h0) begin
            n_fail++;
            $display("FAIL rst_mid_div: got %h expected 0", r_snap);
        end
        run_op(2'b10, 8'h07, 8'h06, 0, 0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({r_to, r_hi, r_lo, r_lat} !== {1'b0, 16'h002A, 32'd22}) begin
            n_fail++;
            $display("FAIL rst_then_mul: got %b/%h%h/%0d expected 0/002A/22",
                     r_to, r_hi, r_lo, r_lat);
        end
    endtask

    task automatic test_back_to_back();
        run_op(2'b01, 8'h10, 8'h30, 0, 0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if ({r_hi, r_lo, r_lat} !== {16'hFFE0, 32'd6}) begin
            n_fail++;
            $display("FAIL b2b_first: got %h%h/%0d expected FFE0/6",
                     r_hi, r_lo, r_lat);
        end
        run_op(2'b01, 8'h90, 8'h21, 0, 0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({r_hi, r_lo, r_lat} !== {16'h006F, 32'd6}) begin
            n_fail++;
            $display("FAIL b2b_second: got %h%h/%0d expected 006F/6",
                     r_hi, r_lo, r_lat);
        end
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic [7:0] x;
        logic [7:0] y;
        int sx;
        int sy;
        int exp_lat;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            x = 8'($urandom);
            y = 8'($urandom);
            if (op == 2'b11) begin
                x = {1'b0, x[6:0]};
                y = {1'b0, y[6:0]};
            end
            if (op == 2'b10 && y == 8'h80) y = 8'h7F;
            sx = $urandom_range(0, 3);
            sy = $urandom_range(0, 3);
            exp_lat = ref_latency(op) + sx + sy;
            run_op(op, x, y, sx, sy, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if ({r_to, r_hi, r_lo, r_lat}
                !== {1'b0, ref_result(op, x, y), exp_lat}) begin
                n_fail++;
                $display("FAIL rand_%0d op%0d %h,%h: got %b/%h%h/%0d expected 0/%h/%0d",
                         i, op, x, y, r_to, r_hi, r_lo, r_lat,
                         ref_result(op, x, y), exp_lat);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.in_valid = 1'b0;
        test_reset();
        test_add();
        test_mul();
        test_div();
        test_div_zero();
        test_stall();
        test_reset_mid_div();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
